// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable Mealy serial pattern detector.
// Define SEQDET_COUNT_EN to build the saturating detection counter.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1101,
    parameter int                 RST_LEN     = 4,
    parameter int                 CNT_W       = 8,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic [CNT_W-1:0]   det_count
);

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;

    logic               len_ok;
    logic               fill_ok;
    logic               hist_ok;
    logic               match;
    logic [MAX_LEN-1:0] hist_sh;
    logic [LEN_W-1:0]   fill_nxt;

    assign len_ok  = (len_r != '0) && (len_r <= LEN_W'(MAX_LEN));
    assign fill_ok = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len_r};

    // Only the newest len_r-1 history bits take part in the compare.
    always_comb begin
        hist_ok = 1'b1;
        for (int k = 1; k < MAX_LEN; k++) begin
            if (k < int'(len_r) && hist[k-1] != pat_r[k]) begin
                hist_ok = 1'b0;
            end
        end
    end

    assign match = in_valid && len_ok && fill_ok &&
                   (in_bit == pat_r[0]) && hist_ok;
    assign out   = match;

    assign hist_sh = {hist, in_bit};

    always_comb begin
        fill_nxt = fill;
        if (match && !ovl_r) begin
            fill_nxt = '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
            fill_nxt = fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            pat_r <= RST_PATTERN;
            len_r <= LEN_W'(RST_LEN);
            ovl_r <= 1'b0;
        end else if (cfg_load) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            fill  <= '0;
        end else if (in_valid) begin
            hist  <= hist_sh[MAX_LEN-2:0];
            fill  <= fill_nxt;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (match && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign det_count = cnt;
`else
    assign det_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param against a bit-list reference model.
// Expected det_count follows SEQDET_COUNT_EN, matching the RTL build.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               out;
    logic [CNT_W-1:0]   det_count;

    seq_detect_param #(
        .MAX_LEN(MAX_LEN),
        .RST_PATTERN(8'b0000_1101),
        .RST_LEN(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .out(out),
        .det_count(det_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic o;
        int   c;
        int   idx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference state: bits seen since the last restart, newest at the back.
    bit       bits_q[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_cnt;

    function automatic bit model_match(bit b);
        if (m_len < 1 || m_len > MAX_LEN) return 1'b0;
        if (bits_q.size() < m_len - 1) return 1'b0;
        if (b != m_pat[0]) return 1'b0;
        for (int k = 1; k < m_len; k++) begin
            if (bits_q[bits_q.size() - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        bits_q.delete();
        m_pat = 8'b0000_1101;
        m_len = 4;
        m_ovl = 1'b0;
        m_cnt = 0;
    endtask

    task automatic step(input bit v, input bit b, input bit ld, input bit rst);
        exp_t e;
        bit   m;
        reset    = rst;
        in_valid = v;
        in_bit   = b;
        cfg_load = ld;
        e.idx    = cyc;
        if (rst) begin
            model_reset();
            e.o = 1'b0;
            e.c = 0;
        end else begin
            m   = v && model_match(b);
            e.o = m;
`ifdef SEQDET_COUNT_EN
            e.c = m_cnt;
`else
            e.c = 0;
`endif
            if (m && m_cnt < CNT_MAX) m_cnt++;
            if (ld) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                bits_q.delete();
            end else if (v) begin
                if (m && !m_ovl) bits_q.delete();
                else begin
                    bits_q.push_back(b);
                    if (bits_q.size() > 16) void'(bits_q.pop_front());
                end
            end
        end
        sb.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input bit [7:0] p, input int l, input bit o);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = o;
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send(input bit [15:0] s, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, s[i], 1'b0, 1'b0);
            idle(gap);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if (out !== e.o) begin
                fails++;
                $display("FAIL out cyc %0d: got %b expected %b", e.idx, out, e.o);
            end
            tests++;
            if (int'(det_count) != e.c || $isunknown(det_count)) begin
                fails++;
                $display("FAIL det_count cyc %0d: got %0d expected %0d",
                         e.idx, det_count, e.c);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send(16'b1101101, 7, 0);
        load(8'h0D, 4, 1'b1);
        send(16'b1101101, 7, 0);
        load(8'h0D, 4, 1'b0);
        send(16'b1101, 4, 2);
        load(8'hA5, 8, 1'b0);
        send(16'hA5A5, 16, 0);
        load(8'h01, 1, 1'b0);
        send(16'b1101, 4, 0);
        send(16'hFFFF, 10, 0);
        load(8'h00, 0, 1'b0);
        send(16'h0000, 12, 1);
        send(16'hD6B3, 16, 0);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(16'b110, 3, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(16'b1, 1, 0);
        send(16'b1101, 4, 0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
            end else if (r < 6) begin
                int lr;
                int l;
                lr = $urandom_range(0, 19);
                l  = (lr == 0) ? 0 : (lr == 1) ? 15 : (lr % 8) + 1;
                if (lr >= 12) l = (lr % 3) + 1;
                load(8'($urandom), l, 1'($urandom));
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 1'b0);
            end
        end

        idle(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
